seg_data_drive: RTL and testbench

Segment-data stage for the six-digit multiplexed seven-segment display. It sits directly downstream of the digit-select scanner and consumes its active-low one-hot `sel`. It accepts a binary distance sample, converts it to six BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives the segment pattern for whichever digit the scanner currently selects. Leading-zero blanking, a fixed decimal point and overflow indication are included.

---
 rtl/seg_data_drive_if.sv | 21 ++
 rtl/seg_data_drive.sv | 170 +++++++++++++++++
 tb/tb_seg_data_drive.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_data_drive_if.sv
// Sample/strobe, digit-select and segment bus between the scanner side and seg_data_drive.
interface seg_data_drive_if #(
    parameter int unsigned DATA_W = 20
);
    logic [DATA_W-1:0] data_in;
    logic              data_vld;
    logic [5:0]        sel;
    logic [7:0]        seg;
    logic [5:0]        sel_o;
    logic              busy;

    modport master (
        output data_in, data_vld, sel,
        input  seg, sel_o, busy
    );

    modport slave (
        input  data_in, data_vld, sel,
        output seg, sel_o, busy
    );
endinterface

// File: rtl/seg_data_drive.sv
// Binary-to-BCD (double-dabble) converter feeding a six-digit multiplexed
// seven-segment driver with leading-zero blanking, fixed dp and overflow dashes.
module seg_data_drive #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned DP_POS = 1,
    parameter int unsigned DP_EN  = 1,
    parameter int unsigned LZB_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_data_drive_if.slave  bus
);
    localparam int unsigned DIGITS  = 6;
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
    localparam int unsigned CMP_W   = (DATA_W > 20) ? DATA_W : 20;
    localparam int unsigned BLANK_FLOOR = (DP_EN != 0) ? DP_POS : 0;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]  disp_q, disp_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic [7:0]        seg_q, seg_d;
    logic [5:0]        sel_o_q;

    function automatic logic [7:0] digit_pat(input logic [3:0] n);
        case (n)
            4'd0:    digit_pat = 8'hC0;
            4'd1:    digit_pat = 8'hF9;
            4'd2:    digit_pat = 8'hA4;
            4'd3:    digit_pat = 8'hB0;
            4'd4:    digit_pat = 8'h99;
            4'd5:    digit_pat = 8'h92;
            4'd6:    digit_pat = 8'h82;
            4'd7:    digit_pat = 8'hF8;
            4'd8:    digit_pat = 8'h80;
            4'd9:    digit_pat = 8'h90;
            default: digit_pat = 8'hFF;
        endcase
    endfunction

    // Add-3 correction of every nibble that would overflow past 9 on the next shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
        end
    end

    // Conversion FSM: capture, DATA_W shift cycles, then a single-cycle display load
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.data_vld) begin
                    state_d    = SHIFT;
                    data_d     = bus.data_in;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = CMP_W'(bus.data_in) > CMP_W'(999999);
                end
            end
            SHIFT: begin
                bcd_d  = {bcd_adj[BCD_W-2:0], data_q[DATA_W-1]};
                data_d = {data_q[DATA_W-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_d  = bcd_q;
                ovf_d   = ovf_pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Segment pattern for the currently selected digit
    always_comb begin
        logic [5:0]       sel_n;
        logic             sel_ok;
        logic [DIGITS-1:0] all_zero;
        logic             acc;
        logic [7:0]       pat;

        sel_n    = ~bus.sel;
        sel_ok   = (sel_n != 6'd0) && ((sel_n & (sel_n - 6'd1)) == 6'd0);
        all_zero = '0;
        acc      = 1'b1;
        pat      = 8'hFF;
        seg_d    = 8'hFF;

        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc         = acc && (disp_q[4*i +: 4] == 4'd0);
            all_zero[i] = acc;
        end

        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (sel_ok && sel_n[k]) begin
                if (ovf_q) begin
                    pat = 8'hBF;
                end else begin
                    if ((LZB_EN != 0) && all_zero[k] && (k > BLANK_FLOOR)) begin
                        pat = 8'hFF;
                    end else begin
                        pat = digit_pat(disp_q[4*k +: 4]);
                    end
                    if ((DP_EN != 0) && (k == DP_POS)) begin
                        pat[7] = 1'b0;
                    end
                end
                seg_d = pat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q   <= 8'hFF;
            sel_o_q <= 6'h3F;
        end else begin
            seg_q   <= seg_d;
            sel_o_q <= bus.sel;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.sel_o = sel_o_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_seg_data_drive.sv
// Randomized self-checking bench for seg_data_drive against an arithmetic display model.
module tb_seg_data_drive;
    localparam int unsigned DATA_W = 20;
    localparam int unsigned DP_POS = 1;
    localparam int unsigned DP_EN  = 1;
    localparam int unsigned LZB_EN = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_data_drive_if #(.DATA_W(DATA_W)) bus ();

    seg_data_drive #(
        .DATA_W(DATA_W), .DP_POS(DP_POS), .DP_EN(DP_EN), .LZB_EN(LZB_EN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int model_val = 0;
    logic [7:0] obs [6];
    logic [5:0] obs_sel [6];

    // Expected segment byte for a number shown on the display and a raw sel
    function automatic logic [7:0] model_seg(input int v, input logic [5:0] s);
        int zeros, k, hi, p;
        int d [6];
        logic [7:0] pat;
        zeros = 0; k = 0; hi = -1; p = v;
        for (int i = 0; i < 6; i++) if (!s[i]) begin zeros++; k = i; end
        if (zeros != 1) return 8'hFF;
        if (v > 999999) return 8'hBF;
        for (int i = 0; i < 6; i++) begin
            d[i] = p % 10;
            p = p / 10;
            if (d[i] != 0) hi = i;
        end
        case (d[k])
            0: pat = 8'hC0; 1: pat = 8'hF9; 2: pat = 8'hA4; 3: pat = 8'hB0;
            4: pat = 8'h99; 5: pat = 8'h92; 6: pat = 8'h82; 7: pat = 8'hF8;
            8: pat = 8'h80; default: pat = 8'h90;
        endcase
        if (LZB_EN != 0 && k > hi && k > ((DP_EN != 0) ? int'(DP_POS) : 0)) pat = 8'hFF;
        if (DP_EN != 0 && k == int'(DP_POS)) pat[7] = 1'b0;
        return pat;
    endfunction

    task automatic scan();
        for (int k = 0; k < 6; k++) begin
            bus.sel = ~(6'b000001 << k);
            @(negedge clk);
            obs[k] = bus.seg;
            obs_sel[k] = bus.sel_o;
        end
        bus.sel = 6'h3F;
    endtask

    task automatic send(input int v);
        bus.data_in  = DATA_W'(v);
        bus.data_vld = 1'b1;
        @(negedge clk);
        bus.data_vld = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.sel = 6'h3E;
        bus.data_in = '0;
        bus.data_vld = 1'b0;
        #22;
        total++; if (bus.seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h exp=ff", bus.seg); end
        total++; if (bus.sel_o !== 6'h3F) begin bad++; $display("FAIL reset_sel_o got=%h exp=3f", bus.sel_o); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        model_val = 0;
        bus.sel = 6'h3E;
        @(negedge clk);
        total++; if (bus.seg !== 8'hC0) begin bad++; $display("FAIL reset_dig0 got=%h exp=c0", bus.seg); end
        bus.sel = 6'h3D;
        @(negedge clk);
        total++; if (bus.seg !== 8'h40) begin bad++; $display("FAIL reset_dig1 got=%h exp=40", bus.seg); end
        bus.sel = 6'h3F;
    endtask

    task automatic test_convert(input int v, input string name);
        int n;
        send(v);
        wait_idle(n);
        total++; if (n != 21) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=21", name, n); end
        model_val = v;
        scan();
        for (int k = 0; k < 6; k++) begin
            total++;
            if (obs[k] !== model_seg(model_val, ~(6'b000001 << k))) begin
                bad++;
                $display("FAIL %s_dig%0d val=%0d got=%h exp=%h", name, k, v, obs[k], model_seg(model_val, ~(6'b000001 << k)));
            end
        end
    endtask

    task automatic test_overflow();
        test_convert(1000000, "ovf");
        test_convert(7, "ovf_clear");
        total++; if (obs[0] !== 8'hF8) begin bad++; $display("FAIL ovf_clear_dig0 got=%h exp=f8", obs[0]); end
    endtask

    task automatic test_drop();
        int n;
        send(42);
        repeat (4) @(negedge clk);
        bus.data_in = DATA_W'(999);
        bus.data_vld = 1'b1;
        @(negedge clk);
        bus.data_vld = 1'b0;
        wait_idle(n);
        total++; if (n != 16) begin bad++; $display("FAIL drop_busy_rest got=%0d exp=16", n); end
        model_val = 42;
        scan();
        total++; if (obs[1] !== 8'h19) begin bad++; $display("FAIL drop_dig1 got=%h exp=19", obs[1]); end
        total++; if (obs[0] !== 8'hA4) begin bad++; $display("FAIL drop_dig0 got=%h exp=a4", obs[0]); end
        total++; if (obs[2] !== model_seg(42, 6'h3B)) begin bad++; $display("FAIL drop_dig2 got=%h exp=%h", obs[2], model_seg(42, 6'h3B)); end
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 12; i++) begin
            v = (i % 2 == 0) ? int'($urandom_range(0, 1048575)) : int'($urandom_range(0, 9999));
            test_convert(v, "rand");
        end
    endtask

    task automatic test_sel();
        logic [5:0] s;
        bus.sel = 6'h3F;
        @(negedge clk);
        total++; if (bus.seg !== 8'hFF) begin bad++; $display("FAIL sel_none got=%h exp=ff", bus.seg); end
        bus.sel = 6'h3C;
        @(negedge clk);
        total++; if (bus.seg !== 8'hFF) begin bad++; $display("FAIL sel_multi got=%h exp=ff", bus.seg); end
        for (int i = 0; i < 10; i++) begin
            s = 6'($urandom_range(0, 63));
            bus.sel = s;
            @(negedge clk);
            total++;
            if (bus.seg !== model_seg(model_val, s)) begin
                bad++; $display("FAIL sel_rand sel=%b got=%h exp=%h", s, bus.seg, model_seg(model_val, s));
            end
            total++;
            if (bus.sel_o !== s) begin bad++; $display("FAIL sel_o_rand got=%b exp=%b", bus.sel_o, s); end
        end
        bus.sel = 6'h3F;
    endtask

    task automatic test_back_to_back();
        int rises [8];
        int nr, n;
        logic prev;
        int v;
        nr = 0;
        v = int'($urandom_range(100000, 999999));
        bus.data_in = DATA_W'(v);
        bus.data_vld = 1'b1;
        for (int c = 0; c < 80; c++) begin
            prev = bus.busy;
            @(negedge clk);
            if (!prev && bus.busy && nr < 8) begin rises[nr] = c; nr++; end
        end
        bus.data_vld = 1'b0;
        total++; if (nr < 3) begin bad++; $display("FAIL b2b_starts got=%0d exp>=3", nr); end
        for (int i = 1; i < 3; i++) begin
            if (i < nr) begin
                total++;
                if (rises[i] - rises[i-1] != 22) begin
                    bad++; $display("FAIL b2b_period got=%0d exp=22", rises[i] - rises[i-1]);
                end
            end
        end
        wait_idle(n);
        total++; if (n >= 200) begin bad++; $display("FAIL b2b_idle got=%0d exp<200", n); end
        model_val = v;
        scan();
        for (int k = 0; k < 6; k++) begin
            total++;
            if (obs[k] !== model_seg(model_val, ~(6'b000001 << k))) begin
                bad++; $display("FAIL b2b_dig%0d got=%h exp=%h", k, obs[k], model_seg(model_val, ~(6'b000001 << k)));
            end
        end
    endtask

    task automatic test_reset_mid();
        send(777777);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        total++; if (bus.seg !== 8'hFF) begin bad++; $display("FAIL rstmid_seg got=%h exp=ff", bus.seg); end
        @(negedge clk);
        rst_n = 1'b1;
        model_val = 0;
        scan();
        total++; if (obs[0] !== 8'hC0) begin bad++; $display("FAIL rstmid_dig0 got=%h exp=c0", obs[0]); end
        total++; if (obs[1] !== 8'h40) begin bad++; $display("FAIL rstmid_dig1 got=%h exp=40", obs[1]); end
        total++; if (obs[5] !== 8'hFF) begin bad++; $display("FAIL rstmid_dig5 got=%h exp=ff", obs[5]); end
        total++; if (obs_sel[3] !== 6'h37) begin bad++; $display("FAIL rstmid_sel_o got=%h exp=37", obs_sel[3]); end
    endtask

    initial begin
        test_reset();
        test_convert(123456, "conv");
        test_convert(5, "blank");
        test_overflow();
        test_drop();
        test_random();
        test_sel();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
